// File: rtl/cipher_frame_tx.sv
//------------------------------------------------------------------------------
// Module   : cipher_frame_tx
// Brief    : Queues {index,data} entries from an upstream cipher and transmits
//            each as a 14-bit serial frame with even parity.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cipher_frame_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic [2:0] in_index,
    output logic       in_ready,
    output logic       tx_out,
    output logic       busy
);

    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CYC_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int c_CNT_W = c_PTR_W + 1;

    localparam logic [c_CYC_W-1:0] c_CYC_LAST = c_CYC_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CYC_W-1:0] c_CYC_ONE  = c_CYC_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_DEPTH    = c_CNT_W'(FIFO_DEPTH);
    localparam logic [3:0]         c_BIT_LAST = 4'd13;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [10:0]          r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic [c_CYC_W-1:0]   r_cyc;
    logic [3:0]           r_bit;
    logic [12:0]          r_shift;
    logic                 r_tx;

    logic                 w_push;
    logic                 w_load;
    logic                 w_fifo_nempty;
    logic                 w_bit_end;
    logic                 w_frame_end;
    logic [10:0]          w_head;
    logic [12:0]          w_frame_rest;

    assign in_ready      = (r_count != c_DEPTH);
    assign w_push        = in_valid & in_ready;
    assign w_fifo_nempty = (r_count != '0);
    assign w_bit_end     = (r_cyc == c_CYC_LAST);
    assign w_frame_end   = w_bit_end & (r_bit == c_BIT_LAST);
    assign w_head        = r_mem[r_rd_ptr];

    // Remaining frame bits after the start bit, LSB transmitted first.
    assign w_frame_rest  = {1'b1, ^w_head, w_head[7:0], w_head[10:8]};

    assign tx_out = r_tx;
    assign busy   = (r_state == SHIFT) | w_fifo_nempty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_fifo_nempty) begin
                    w_load      = 1'b1;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (w_frame_end) begin
                    if (w_fifo_nempty) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wr_ptr] <= {in_index, in_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_load) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_load})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cyc   <= '0;
            r_bit   <= '0;
            r_shift <= '1;
            r_tx    <= 1'b1;
        end else if (w_load) begin
            r_cyc   <= '0;
            r_bit   <= '0;
            r_shift <= w_frame_rest;
            r_tx    <= 1'b0;
        end else if (r_state == SHIFT) begin
            if (w_bit_end) begin
                r_cyc <= '0;
                if (r_bit == c_BIT_LAST) begin
                    r_bit <= '0;
                    r_tx  <= 1'b1;
                end else begin
                    r_bit   <= r_bit + 4'd1;
                    r_tx    <= r_shift[0];
                    r_shift <= {1'b1, r_shift[12:1]};
                end
            end else begin
                r_cyc <= r_cyc + c_CYC_ONE;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cipher_frame_tx.sv
//------------------------------------------------------------------------------
// Module   : tb_cipher_frame_tx
// Brief    : Directed self-checking bench for cipher_frame_tx.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_cipher_frame_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic [2:0] in_index;
    logic       in_ready;
    logic       tx_out;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    cipher_frame_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_index (in_index),
        .in_ready (in_ready),
        .tx_out   (tx_out),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called in cycle 0 of a start bit; returns one sample per frame bit and
    // the number of cycles where a bit changed before its slot ended.
    task automatic capture_frame(output logic [13:0] bits, output int unstable);
        bits     = '0;
        unstable = 0;
        for (int b = 0; b < 14; b++) begin
            for (int c = 0; c < CPB; c++) begin
                if (c == 0) bits[b] = tx_out;
                else if (tx_out !== bits[b]) unstable++;
                step();
            end
        end
    endtask

    logic [13:0] bits_a;
    logic [13:0] bits_b;
    int          unst_a;
    int          unst_b;
    int          bad;
    int          accepted;
    int          waited;

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_index = 3'd0;

        // Reset and idle line
        step();
        step();
        rst = 1'b0;
        check("reset_tx_out",   32'(tx_out),   32'd1);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_busy",     32'(busy),     32'd0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (tx_out !== 1'b1) bad++;
            step();
        end
        check("idle_line_high", 32'(bad), 32'd0);

        // Single frame idx=3 data=0xA5
        in_valid = 1'b1;
        in_index = 3'd3;
        in_data  = 8'hA5;
        step();
        in_valid = 1'b0;
        check("single_busy_after_push", 32'(busy),   32'd1);
        check("single_tx_still_idle",   32'(tx_out), 32'd1);
        step();
        check("single_latency_start", 32'(tx_out), 32'd0);
        capture_frame(bits_a, unst_a);
        check("single_frame_bits",   32'(bits_a), 32'h2A56);
        check("single_bit_duration", 32'(unst_a), 32'd0);
        check("single_end_busy",     32'(busy),   32'd0);
        check("single_end_tx",       32'(tx_out), 32'd1);

        // Back-to-back frames
        in_valid = 1'b1;
        in_index = 3'd0;
        in_data  = 8'h00;
        step();
        in_index = 3'd7;
        in_data  = 8'hFF;
        step();
        in_valid = 1'b0;
        check("b2b_first_start", 32'(tx_out), 32'd0);
        capture_frame(bits_a, unst_a);
        check("b2b_no_gap", 32'(tx_out), 32'd0);
        capture_frame(bits_b, unst_b);
        check("b2b_frame_a",   32'(bits_a), 32'h2000);
        check("b2b_frame_b",   32'(bits_b), 32'h3FFE);
        check("b2b_parity_a",  32'(bits_a[12]), 32'd0);
        check("b2b_parity_b",  32'(bits_b[12]), 32'd1);
        check("b2b_stable",    32'(unst_a + unst_b), 32'd0);
        check("b2b_end_busy",  32'(busy), 32'd0);

        // Back-pressure with in_valid held high
        accepted = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data  = 8'hC0 + 8'(accepted);
            in_index = 3'(accepted);
            if (in_ready) accepted++;
            step();
        end
        check("bp_accepted",    32'(accepted), 32'd5);
        check("bp_ready_low",   32'(in_ready), 32'd0);
        waited = 0;
        while (!in_ready && waited < 200) begin
            step();
            waited++;
        end
        in_valid = 1'b0;
        check("bp_ready_return_cycles", 32'(waited), 32'd48);
        check("bp_next_start", 32'(tx_out), 32'd0);
        capture_frame(bits_a, unst_a);
        check("bp_fifo_order_frame", 32'(bits_a), 32'h2C12);
        check("bp_frame_stable",     32'(unst_a),  32'd0);

        // Reset at bit 6 with two entries still queued
        for (int i = 0; i < 6 * CPB; i++) step();
        check("midrst_busy_before", 32'(busy), 32'd1);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_index = 3'd5;
        in_data  = 8'h5A;
        step();
        check("midrst_tx_out",   32'(tx_out),   32'd1);
        check("midrst_busy",     32'(busy),     32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        check("rst_blocks_push", 32'(busy), 32'd0);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (tx_out !== 1'b1 || busy !== 1'b0) bad++;
            step();
        end
        check("midrst_no_resume", 32'(bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
